// File: rtl/dcache_arb_pkg.sv
// Shared types for the two-way data-cache port arbiter.
package dcache_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
  } cache_req_t;

  localparam cache_req_t NO_REQ = '0;

endpackage

// File: rtl/dcache_arb_if.sv
// Requester-side and cache-side bus of the data-cache arbiter.
interface dcache_arb_if;
  logic        r0_rd, r0_wr;
  logic [31:0] r0_addr, r0_wr_data, r0_data;
  logic [3:0]  r0_wr_be;
  logic        r0_waitrequest;

  logic        r1_rd, r1_wr;
  logic [31:0] r1_addr, r1_wr_data, r1_data;
  logic [3:0]  r1_wr_be;
  logic        r1_waitrequest;

  logic        cache_rd, cache_wr;
  logic [31:0] cache_addr, cache_wr_data, cache_data;
  logic [3:0]  cache_wr_be;
  logic        cache_waitrequest;

  modport slave (
    input  r0_rd, r0_wr, r0_addr, r0_wr_data, r0_wr_be,
    output r0_data, r0_waitrequest,
    input  r1_rd, r1_wr, r1_addr, r1_wr_data, r1_wr_be,
    output r1_data, r1_waitrequest,
    output cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
    input  cache_data, cache_waitrequest
  );

  modport master (
    output r0_rd, r0_wr, r0_addr, r0_wr_data, r0_wr_be,
    input  r0_data, r0_waitrequest,
    output r1_rd, r1_wr, r1_addr, r1_wr_data, r1_wr_be,
    input  r1_data, r1_waitrequest,
    input  cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
    output cache_data, cache_waitrequest
  );
endinterface

// File: rtl/dcache_arb.sv
// Round-robin arbiter sharing one data-cache port between two requesters;
// the grant is held while the cache stalls the granted transaction.
module dcache_arb
  import dcache_arb_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  dcache_arb_if.slave  bus,
  output logic         proto_err
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic       perr_q, perr_d;

  logic [1:0] req;
  logic       gnt_vld, gnt, owner_req, fwd;
  cache_req_t req0, req1, sel;

  // Returns {valid, id}: the pointer's requester if active, else the other.
  function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic ptr);
    rr_pick = {|r, r[ptr] ? ptr : ~ptr};
  endfunction

  assign req  = {bus.r1_rd | bus.r1_wr, bus.r0_rd | bus.r0_wr};
  assign req0 = '{rd: bus.r0_rd, wr: bus.r0_wr, addr: bus.r0_addr,
                  wr_data: bus.r0_wr_data, wr_be: bus.r0_wr_be};
  assign req1 = '{rd: bus.r1_rd, wr: bus.r1_wr, addr: bus.r1_addr,
                  wr_data: bus.r1_wr_data, wr_be: bus.r1_wr_be};

  always_comb begin
    {gnt_vld, gnt} = rr_pick(req, rr_q);
    if (state_q == LOCKED) begin
      gnt_vld = 1'b1;
      gnt     = owner_q;
    end
    owner_req = req[gnt];
    // A locked owner that dropped its request is not forwarded.
    fwd = gnt_vld && owner_req && !reset;
    sel = fwd ? (gnt ? req1 : req0) : NO_REQ;
  end

  assign bus.cache_rd       = sel.rd;
  assign bus.cache_wr       = sel.wr;
  assign bus.cache_addr     = sel.addr;
  assign bus.cache_wr_data  = sel.wr_data;
  assign bus.cache_wr_be    = sel.wr_be;
  assign bus.r0_waitrequest = !(fwd && !gnt) || bus.cache_waitrequest;
  assign bus.r1_waitrequest = !(fwd && gnt)  || bus.cache_waitrequest;
  assign bus.r0_data        = bus.cache_data;
  assign bus.r1_data        = bus.cache_data;
  assign proto_err          = perr_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          if (bus.cache_waitrequest) begin
            state_d = LOCKED;
            owner_d = gnt;
          end else begin
            rr_d = ~gnt;
          end
        end
      end
      LOCKED: begin
        if (!owner_req) begin
          perr_d  = 1'b1;
          state_d = IDLE;
        end else if (!bus.cache_waitrequest) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_dcache_arb.sv
// Self-checking bench for dcache_arb: directed cycles plus a completion scoreboard.
module tb_dcache_arb;
  import dcache_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic proto_err;

  dcache_arb_if bus();

  dcache_arb dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .proto_err (proto_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        id;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic id, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data);
    exp_t e;
    e.id = id; e.wr = wr; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    bus.r0_rd = rd; bus.r0_wr = wr; bus.r0_addr = addr;
    bus.r0_wr_data = data; bus.r0_wr_be = be;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
    bus.r1_rd = rd; bus.r1_wr = wr; bus.r1_addr = addr;
    bus.r1_wr_data = data; bus.r1_wr_be = be;
  endtask

  task automatic idle_all();
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Completion monitor: every zero-wait strobe retires the oldest expectation.
  initial begin : mon
    exp_t e;
    logic id;
    forever begin
      @(negedge clock);
      if ((bus.cache_rd || bus.cache_wr) && !bus.cache_waitrequest) begin
        check("sb_one_served", 32'(bus.r0_waitrequest ^ bus.r1_waitrequest), 32'd1);
        id = bus.r0_waitrequest;
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_id", 32'(id), 32'(e.id));
          check("sb_wr", 32'(bus.cache_wr), 32'(e.wr));
          check("sb_addr", bus.cache_addr, e.addr);
          if (e.wr) check("sb_wdata", bus.cache_wr_data, e.data);
        end
      end
    end
  end

  initial begin
    logic [31:0] a0, a1;
    logic        id;

    reset = 1'b1;
    idle_all();
    bus.cache_waitrequest = 1'b0;
    bus.cache_data        = 32'hDEADBEEF;
    drive0(1'b1, 1'b0, 32'h40, '0, '0);
    #2;
    check("rst_cache_rd", 32'(bus.cache_rd), 32'd0);
    check("rst_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
    tick();
    tick();

    // Reset released, no requests
    reset = 1'b0;
    idle_all();
    #2;
    check("idle_cache_rd", 32'(bus.cache_rd), 32'd0);
    check("idle_cache_wr", 32'(bus.cache_wr), 32'd0);
    check("idle_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
    check("idle_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    check("idle_perr", 32'(proto_err), 32'd0);
    tick();

    // Single zero-wait read from r0
    drive0(1'b1, 1'b0, 32'h100, '0, '0);
    push(1'b0, 1'b0, 32'h100, '0);
    #2;
    check("rd_cache_rd", 32'(bus.cache_rd), 32'd1);
    check("rd_addr", bus.cache_addr, 32'h100);
    check("rd_r0_wait", 32'(bus.r0_waitrequest), 32'd0);
    check("rd_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    check("rd_r0_data", bus.r0_data, 32'hDEADBEEF);
    tick();

    // Pointer moved to r1
    drive0(1'b1, 1'b0, 32'h104, '0, '0);
    drive1(1'b1, 1'b0, 32'h204, '0, '0);
    push(1'b1, 1'b0, 32'h204, '0);
    #2;
    check("rr1_r1_wait", 32'(bus.r1_waitrequest), 32'd0);
    check("rr1_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
    tick();

    reset = 1'b1;
    idle_all();
    tick();
    reset = 1'b0;

    // Both requesting continuously: strict alternation starting at r0
    a0 = 32'h1000;
    a1 = 32'h2000;
    for (int unsigned i = 0; i < 8; i++) begin
      drive0(1'b1, 1'b0, a0, '0, '0);
      drive1(1'b1, 1'b0, a1, '0, '0);
      id = i[0];
      push(id, 1'b0, id ? a1 : a0, '0);
      #2;
      check("alt_r0_wait", 32'(bus.r0_waitrequest), 32'(id));
      check("alt_r1_wait", 32'(bus.r1_waitrequest), 32'(!id));
      if (id) a1 += 32'd4;
      else    a0 += 32'd4;
      tick();
    end
    idle_all();

    // r0 alone, so r1 holds priority for the stalled write
    drive0(1'b1, 1'b0, 32'h2FC, '0, '0);
    push(1'b0, 1'b0, 32'h2FC, '0);
    #2;
    check("pre_r0_wait", 32'(bus.r0_waitrequest), 32'd0);
    tick();

    drive0(1'b1, 1'b0, 32'h300, '0, '0);
    drive1(1'b0, 1'b1, 32'h200, 32'h12345678, 4'hF);
    push(1'b1, 1'b1, 32'h200, 32'h12345678);
    for (int unsigned k = 0; k < 4; k++) begin
      bus.cache_waitrequest = (k < 3);
      #2;
      check("lock_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
      check("lock_r1_wait", 32'(bus.r1_waitrequest), 32'(k < 3));
      check("lock_addr", bus.cache_addr, 32'h200);
      check("lock_be", 32'(bus.cache_wr_be), 32'hF);
      tick();
    end
    drive1(1'b0, 1'b0, '0, '0, '0);
    bus.cache_waitrequest = 1'b0;
    push(1'b0, 1'b0, 32'h300, '0);
    #2;
    check("post_lock_r0_wait", 32'(bus.r0_waitrequest), 32'd0);
    check("post_lock_addr", bus.cache_addr, 32'h300);
    tick();

    // r1 completes so the pointer returns to r0
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b1, 1'b0, 32'h4F0, '0, '0);
    push(1'b1, 1'b0, 32'h4F0, '0);
    #2;
    check("pre_drop_r1_wait", 32'(bus.r1_waitrequest), 32'd0);
    tick();

    // r0 locks, then drops its request while the cache still stalls
    drive1(1'b0, 1'b0, '0, '0, '0);
    drive0(1'b1, 1'b0, 32'h400, '0, '0);
    bus.cache_waitrequest = 1'b1;
    #2;
    check("drop_lock_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
    check("drop_lock_addr", bus.cache_addr, 32'h400);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    drive1(1'b1, 1'b0, 32'h500, '0, '0);
    #2;
    check("drop_cache_rd", 32'(bus.cache_rd), 32'd0);
    check("drop_cache_wr", 32'(bus.cache_wr), 32'd0);
    check("drop_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    check("drop_perr_pre", 32'(proto_err), 32'd0);
    tick();
    bus.cache_waitrequest = 1'b0;
    drive0(1'b1, 1'b0, 32'h600, '0, '0);
    push(1'b0, 1'b0, 32'h600, '0);
    #2;
    check("drop_perr", 32'(proto_err), 32'd1);
    check("drop_rr_r0_wait", 32'(bus.r0_waitrequest), 32'd0);
    check("drop_rr_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    push(1'b1, 1'b0, 32'h500, '0);
    #2;
    check("drop_next_r1_wait", 32'(bus.r1_waitrequest), 32'd0);
    check("drop_perr_sticky", 32'(proto_err), 32'd1);
    tick();

    // Reset while r1 holds a stalled write
    drive1(1'b0, 1'b1, 32'h700, 32'hA5A5A5A5, 4'h3);
    bus.cache_waitrequest = 1'b1;
    #2;
    check("rlock_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    check("rlock_cache_wr", 32'(bus.cache_wr), 32'd1);
    tick();
    reset = 1'b1;
    #2;
    check("rlock_comb_wr", 32'(bus.cache_wr), 32'd0);
    check("rlock_comb_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
    check("rlock_comb_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    tick();
    #1;
    check("rlock_perr_clr", 32'(proto_err), 32'd0);
    reset = 1'b0;
    idle_all();
    bus.cache_waitrequest = 1'b0;
    #1;
    check("rlock_idle_r0_wait", 32'(bus.r0_waitrequest), 32'd1);
    check("rlock_idle_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    tick();
    drive0(1'b1, 1'b0, 32'h800, '0, '0);
    drive1(1'b1, 1'b0, 32'h900, '0, '0);
    push(1'b0, 1'b0, 32'h800, '0);
    #2;
    check("rlock_rr_r0_wait", 32'(bus.r0_waitrequest), 32'd0);
    check("rlock_rr_r1_wait", 32'(bus.r1_waitrequest), 32'd1);
    tick();
    drive0(1'b0, 1'b0, '0, '0, '0);
    push(1'b1, 1'b0, 32'h900, '0);
    #2;
    check("rlock_next_r1_wait", 32'(bus.r1_waitrequest), 32'd0);
    tick();
    idle_all();
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
